// File: rtl/pump_bank_controller_pkg.sv
// Shared encodings and helpers for the pump bank controller.
// The FSM states, sensor bit positions and pump bit positions are defined here.
package pump_bank_controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF   = 2'd0,
    ST_BOOST = 2'd1,
    ST_LEAD  = 2'd2,
    ST_FAULT = 2'd3
  } pump_state_e;

  localparam int I_BIT  = 0;
  localparam int S_BIT  = 1;
  localparam int B1_BIT = 0;
  localparam int B2_BIT = 1;

  // Pump drive pattern is a pure function of registered state and lead.
  function automatic logic [1:0] pump_drive(pump_state_e st, logic lead);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      ST_BOOST: d = 2'b11;
      ST_LEAD: begin
        d[B1_BIT] = ~lead;
        d[B2_BIT] = lead;
      end
      default: d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pump_bank_controller_if.sv
// Bundle of per-tank control inputs and pump/status outputs for the bank.
// No valid/ready: every input is level-sampled on each rising clock and every output is valid every cycle.
interface pump_bank_controller_if #(
  parameter int NUM_TANKS = 2
);
  logic [NUM_TANKS-1:0]   enable;
  logic [NUM_TANKS-1:0]   fault_clear;
  logic [2*NUM_TANKS-1:0] level_sensors;
  logic [2*NUM_TANKS-1:0] pumps;
  logic [NUM_TANKS-1:0]   fault;
  logic [NUM_TANKS-1:0]   lead;
  logic [2*NUM_TANKS-1:0] current_state;

  modport master (
    output enable, fault_clear, level_sensors,
    input  pumps, fault, lead, current_state
  );

  modport slave (
    input  enable, fault_clear, level_sensors,
    output pumps, fault, lead, current_state
  );
endinterface

// File: rtl/pump_bank_controller_channel.sv
// One tank: two sensor debouncers, the hysteresis FSM, the min-on counter and the lead flip-flop.
// Outputs decode from registered state and lead only (Moore).
module pump_channel
  import pump_bank_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int MIN_ON_CYCLES   = 8,
  parameter int CNT_W           = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               fault_clear_i,
  input  logic [1:0]         sensors_i,
  output logic [1:0]         pumps_o,
  output logic               fault_o,
  output logic               lead_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [7:0]       DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(MIN_ON_CYCLES);

  logic [1:0]       filt_q, filt_d;
  logic [7:0]       deb_q [2];
  logic [7:0]       deb_d [2];
  pump_state_e      state_q, state_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic             lead_q, lead_d;
  logic             lo, hi;

  // A counter runs only while raw disagrees with filtered; the filtered bit flips on the last sample.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      filt_d[s] = filt_q[s];
      deb_d[s]  = 8'd0;
      if (sensors_i[s] != filt_q[s]) begin
        if (deb_q[s] == DEB_LAST) filt_d[s] = sensors_i[s];
        else                      deb_d[s]  = deb_q[s] + 8'd1;
      end
    end
  end

  assign lo = filt_q[I_BIT];
  assign hi = filt_q[S_BIT];

  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    min_d   = min_q;
    if ((state_q == ST_BOOST || state_q == ST_LEAD) && min_q != '0) min_d = min_q - 1'b1;

    if (!enable_i) begin
      state_d = (state_q == ST_FAULT) ? ST_FAULT : ST_OFF;
      min_d   = '0;
    end else if (hi && !lo) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (!lo) begin
            state_d = ST_BOOST;
            min_d   = MIN_LOAD;
          end
        end
        ST_BOOST: begin
          if (lo && !hi) begin
            state_d = ST_LEAD;
          end else if (hi && min_q == '0) begin
            state_d = ST_OFF;
            lead_d  = ~lead_q;
          end
        end
        ST_LEAD: begin
          if (!lo) begin
            state_d = ST_BOOST;
          end else if (hi && min_q == '0) begin
            state_d = ST_OFF;
            lead_d  = ~lead_q;
          end
        end
        ST_FAULT: begin
          // Sensors are known consistent here, so the acknowledge alone releases the latch.
          if (fault_clear_i) state_d = ST_OFF;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q   <= 2'b11;
      deb_q[0] <= 8'd0;
      deb_q[1] <= 8'd0;
      state_q  <= ST_OFF;
      min_q    <= '0;
      lead_q   <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      deb_q[0] <= deb_d[0];
      deb_q[1] <= deb_d[1];
      state_q  <= state_d;
      min_q    <= min_d;
      lead_q   <= lead_d;
    end
  end

  assign pumps_o = pump_drive(state_q, lead_q);
  assign fault_o = (state_q == ST_FAULT);
  assign lead_o  = lead_q;
  assign state_o = state_q;

endmodule

// File: rtl/pump_bank_controller.sv
// Bank of independent tank channels; the top only slices the shared buses per tank.
module pump_bank_controller
  import pump_bank_controller_pkg::*;
#(
  parameter int NUM_TANKS       = 2,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int MIN_ON_CYCLES   = 8,
  parameter int CNT_W           = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  pump_bank_controller_if.slave bus
);

  logic [2*NUM_TANKS-1:0] pumps_w;
  logic [2*NUM_TANKS-1:0] state_w;
  logic [NUM_TANKS-1:0]   fault_w;
  logic [NUM_TANKS-1:0]   lead_w;

  for (genvar c = 0; c < NUM_TANKS; c++) begin : g_ch
    pump_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .MIN_ON_CYCLES  (MIN_ON_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_i        (clock),
      .rst_ni       (reset_n),
      .enable_i     (bus.enable[c]),
      .fault_clear_i(bus.fault_clear[c]),
      .sensors_i    (bus.level_sensors[2*c +: 2]),
      .pumps_o      (pumps_w[2*c +: 2]),
      .fault_o      (fault_w[c]),
      .lead_o       (lead_w[c]),
      .state_o      (state_w[2*c +: 2])
    );
  end

  assign bus.pumps         = pumps_w;
  assign bus.current_state = state_w;
  assign bus.fault         = fault_w;
  assign bus.lead          = lead_w;

endmodule
